// File: rtl/chacha_pkg.sv
// Shared ChaCha definitions: the constant words, the key/nonce layout,
// the state-builder FSM encoding and a helper that packs the 16-word state.
package chacha_pkg;

    localparam int unsigned STATE_W     = 512;
    localparam int unsigned WORD_W      = 32;
    localparam int unsigned KEY_WORDS   = 8;
    localparam int unsigned NONCE_WORDS = 3;
    localparam int unsigned TRNG_WORDS  = KEY_WORDS + NONCE_WORDS;
    localparam int unsigned SLOT_W      = TRNG_WORDS * WORD_W;

    // "expand 32-byte k"
    localparam logic [31:0] CHACHA_CONST0 = 32'h6170_7865;
    localparam logic [31:0] CHACHA_CONST1 = 32'h3320_646e;
    localparam logic [31:0] CHACHA_CONST2 = 32'h7962_2d32;
    localparam logic [31:0] CHACHA_CONST3 = 32'h6b20_6574;

    typedef enum logic [1:0] {
        SB_IDLE = 2'd0,
        SB_REQ  = 2'd1,
        SB_HOLD = 2'd2,
        SB_ERR  = 2'd3
    } sb_state_e;

    // Slots 0..7 are key words 4..11, slots 8..10 are nonce words 13..15,
    // and the block counter sits in word 12 between them.
    function automatic logic [STATE_W-1:0] assemble_state(
        input logic [SLOT_W-1:0] slots,
        input logic [31:0]       ctr
    );
        assemble_state = {slots[SLOT_W-1:KEY_WORDS*WORD_W],
                          ctr,
                          slots[KEY_WORDS*WORD_W-1:0],
                          CHACHA_CONST3, CHACHA_CONST2,
                          CHACHA_CONST1, CHACHA_CONST0};
    endfunction

endpackage

// File: rtl/chacha_state_builder.sv
// Collects 11 TRNG words plus a block counter into a ChaCha initial state
// and holds it for the ChaCha20 core until the consumer acknowledges it.
//
// state | meaning
// IDLE  | waiting for build_start, data registers zero
// REQ   | requesting TRNG words, filling slot[index]
// HOLD  | state_out valid, waiting for state_ack
// ERR   | TRNG timed out, err set, key/nonce zeroized
module chacha_state_builder
    import chacha_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               build_start,
    input  logic [31:0]        counter_init,
    input  logic [31:0]        trng_data,
    input  logic               trng_ready,
    output logic               trng_request,
    output logic               busy,
    output logic               state_valid,
    input  logic               state_ack,
    output logic [STATE_W-1:0] state_out,
    output logic               err
);

    localparam int unsigned TMO_W    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);
    localparam logic [TMO_W-1:0] TMO_END  = TMO_W'(TIMEOUT_CYCLES);
    localparam logic [3:0]       IDX_LAST = 4'(TRNG_WORDS - 1);

    sb_state_e          state_q, state_d;
    logic [3:0]         idx_q, idx_d;
    logic [TMO_W-1:0]   tmo_q, tmo_d;
    logic               err_q, err_d;
    logic [31:0]        ctr_q, ctr_d;
    logic [SLOT_W-1:0]  slot_q, slot_d;

    // FSM state register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= SB_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Index, timeout, error flag and captured data registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            idx_q  <= '0;
            tmo_q  <= '0;
            err_q  <= 1'b0;
            ctr_q  <= '0;
            slot_q <= '0;
        end else begin
            idx_q  <= idx_d;
            tmo_q  <= tmo_d;
            err_q  <= err_d;
            ctr_q  <= ctr_d;
            slot_q <= slot_d;
        end
    end

    // Next-state and datapath update
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        tmo_d   = tmo_q;
        err_d   = err_q;
        ctr_d   = ctr_q;
        slot_d  = slot_q;
        unique case (state_q)
            SB_IDLE, SB_ERR: begin
                if (build_start) begin
                    state_d = SB_REQ;
                    idx_d   = '0;
                    tmo_d   = '0;
                    err_d   = 1'b0;
                    ctr_d   = counter_init;
                    slot_d  = '0;
                end
            end
            SB_REQ: begin
                if (trng_ready) begin
                    for (int i = 0; i < int'(TRNG_WORDS); i++) begin
                        if (idx_q == 4'(i)) begin
                            slot_d[i*WORD_W +: WORD_W] = trng_data;
                        end
                    end
                    tmo_d = '0;
                    // The last capture moves straight to HOLD so no extra word is requested
                    if (idx_q == IDX_LAST) begin
                        state_d = SB_HOLD;
                    end else begin
                        idx_d = idx_q + 4'd1;
                    end
                end else if (tmo_q == TMO_LAST) begin
                    state_d = SB_ERR;
                    tmo_d   = TMO_END;
                    err_d   = 1'b1;
                    slot_d  = '0;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
            end
            SB_HOLD: begin
                // A start arriving with the ack is dropped, not queued
                if (state_ack) begin
                    state_d = SB_IDLE;
                    idx_d   = '0;
                    ctr_d   = '0;
                    slot_d  = '0;
                end
            end
            default: begin
                state_d = SB_IDLE;
            end
        endcase
    end

    // Status outputs decoded from the state register
    always_comb begin
        trng_request = (state_q == SB_REQ);
        busy         = (state_q == SB_REQ) || (state_q == SB_HOLD);
        state_valid  = (state_q == SB_HOLD);
        err          = err_q;
        state_out    = state_valid ? assemble_state(slot_q, ctr_q) : '0;
    end

endmodule

// File: doc/chacha_state_builder.md
CHACHA_STATE_BUILDER -- requirements
Module: chacha_state_builder

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset, with ports named clk and rst as elsewhere in the codebase.
REQ-002 Parameter TIMEOUT_CYCLES, default 1024: the maximum number of cycles spent waiting for one TRNG word.
REQ-003 clk  input  1  is the system clock, and all state SHALL update on its rising edge.
REQ-004 rst  input  1  is the asynchronous, active-low reset.
REQ-005 build_start  input  1  is a one-cycle request to assemble a new 512-bit ChaCha initial state.
REQ-006 counter_init  input  32  is the block-counter value, sampled on the cycle build_start is accepted.
REQ-007 trng_data  input  32  is the random word from the TRNG, valid when trng_ready=1.
REQ-008 trng_ready  input  1  is the TRNG data-valid strobe.
REQ-009 trng_request  output  1  requests a TRNG word and SHALL be driven combinationally as (state==REQ).
REQ-010 busy  output  1  SHALL be 1 in the REQ and HOLD states.
REQ-011 state_valid  output  1  SHALL indicate that state_out holds a complete state (HOLD).
REQ-012 state_ack  input  1  is the consumer's acceptance of state_out.
REQ-013 state_out  output  512  is the assembled state, with word i at bits [32i+31:32i].
REQ-014 err  output  1  is a sticky TRNG-timeout flag.

Function
REQ-015 The FSM SHALL have the states IDLE, REQ, HOLD and ERR, and SHALL use a 2-bit encoding.
REQ-016 IDLE: on build_start=1 the FSM SHALL move to REQ, capture counter_init, clear the word index and the timeout counter, and clear err.
REQ-017 REQ: on each rising edge with trng_ready=1, trng_data SHALL be stored into slot[index], index SHALL increment, and the timeout counter SHALL clear.
REQ-018 The slot order SHALL be fixed:
- index 0..7 fill key words 4..11.
- index 8..10 fill nonce words 13..15.
- The total is 11 TRNG words, held in a 4-bit index with no wrap past 10.
REQ-019 When the capture at index 10 occurs, the FSM SHALL enter HOLD on that edge, so no 12th word is ever requested or captured.
REQ-020 With trng_ready tied high, state_valid SHALL rise exactly 11 cycles after the edge at which build_start was sampled.
REQ-021 In REQ, each cycle with trng_ready=0 SHALL increment the timeout counter; on reaching TIMEOUT_CYCLES the FSM SHALL go to ERR and set err=1.
REQ-022 The constant words SHALL be word0=0x61707865, word1=0x3320646e, word2=0x79622d32 and word3=0x6b206574.
REQ-023 Word 12 SHALL be the captured counter_init.
REQ-024 state_out SHALL equal the assembled state while state_valid=1, and SHALL be all zeros otherwise.
REQ-025 HOLD: state_out SHALL remain stable until state_ack=1; on that edge the FSM SHALL go to IDLE and zeroize all key, nonce and counter registers.
REQ-026 ERR: the key and nonce registers SHALL be zeroized on entry; build_start SHALL leave ERR exactly as in IDLE, clearing err.
REQ-027 build_start in REQ or HOLD SHALL be ignored.
REQ-028 build_start and state_ack asserted in the same HOLD cycle SHALL complete the ack only; the start SHALL not be queued.
REQ-029 state_ack outside HOLD SHALL be ignored.
REQ-030 trng_ready outside REQ SHALL be ignored, with no capture and no index change.

Reset
REQ-031 rst=0 SHALL asynchronously force:
- state=IDLE, index=0, timeout counter=0.
- All data registers zero.
- trng_request=0, busy=0, state_valid=0, err=0, state_out=0.
REQ-032 Reset asserted mid-REQ or mid-HOLD SHALL discard all partial data; after release the block SHALL require a new build_start.

Structure
REQ-033 The four ChaCha constants, the key/nonce word counts (8 and 3), the FSM state encoding and the 512-bit state width SHALL live in the shared package chacha_pkg, alongside the ChaCha20 core.
REQ-034 The block SHALL be a single module with no sub-modules; it SHALL sit between the TRNG and the ChaCha20 in_state/start inputs.

Verification
REQ-035 Back-to-back words: trng_ready held 1, trng_data = 0x00000001..0x0000000B, counter_init=0x00000007 -> state_valid rises 11 cycles after start; words 4..11 = 1..8, word12 = 7, words 13..15 = 9..11, words 0..3 = the constants.
REQ-036 Stalled TRNG: trng_ready pulses every 5th cycle -> exactly 11 captures, trng_request low from HOLD onwards, same layout as REQ-035.
REQ-037 Timeout: TIMEOUT_CYCLES=16, trng_ready=0 after 3 words -> err=1 and FSM in ERR at the 16th stalled cycle; a new build_start clears err and rebuilds correctly.
REQ-038 Handshake: hold state_ack=0 for 20 cycles -> state_out stable; ack with a simultaneous build_start -> IDLE, state_out=0, no new build.
REQ-039 Reset mid-build: rst=0 after 5 captures -> all outputs 0 immediately; a subsequent build_start yields a fresh 11-word state with no stale words.
